pe_array_feeder: RTL

Systolic input sequencer that drives the west (a) and north (b) edges of an N×N array of PE_module processing elements. It buffers one N×N A matrix and one N×N B matrix written over a simple load port. On `start` it emits the diagonally skewed operand streams the array consumes, then zero-pads for a drain interval so the last products can propagate. It is the transmit end of the PE `a`/`b` operand interface.

---
 rtl/pe_feed_pkg.sv | 15 +
 rtl/pe_array_feeder_if.sv | 31 +++
 rtl/pe_feed_mem.sv | 44 ++++
 rtl/pe_array_feeder.sv | 90 +++++++++
 4 files changed

// File: rtl/pe_feed_pkg.sv
// Shared types and helpers for the systolic PE-array input sequencer.
package pe_feed_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam int PE_DW = 8;
    localparam int PE_N  = 4;

    // True when step t puts a real operand on lane i (0 <= t-i < n); the
    // t >= i test keeps a negative offset from aliasing via wrap-around.
    function automatic logic lane_idx_ok(input int t, input int i, input int n);
        return (t >= i) && ((t - i) < n);
    endfunction

endpackage

// File: rtl/pe_array_feeder_if.sv
// Load port, start strobe and skewed operand outputs of the PE-array feeder.
interface pe_array_feeder_if
    import pe_feed_pkg::*;
#(
    parameter int N  = PE_N,
    parameter int DW = PE_DW
);
    localparam int AW = $clog2(N);

    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_row;
    logic [AW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            valid_out;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, valid_out, a_out, b_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, valid_out, a_out, b_out
    );
endinterface

// File: rtl/pe_feed_mem.sv
// A/B operand register file with a single write port and two skewed N-lane
// read ports addressed by stream step t.
module pe_feed_mem
    import pe_feed_pkg::*;
#(
    parameter int N  = PE_N,
    parameter int DW = PE_DW,
    parameter int AW = $clog2(N),
    parameter int TW = $clog2(2*N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic            i_wr_sel,
    input  logic [AW-1:0]   i_wr_row,
    input  logic [AW-1:0]   i_wr_col,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [TW-1:0]   i_t,
    output logic [N*DW-1:0] o_a,
    output logic [N*DW-1:0] o_b
);
    logic [N-1:0][N-1:0][DW-1:0] r_a;
    logic [N-1:0][N-1:0][DW-1:0] r_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_wr_en) begin
            if (i_wr_sel) r_b[i_wr_row][i_wr_col] <= i_wr_data;
            else          r_a[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    // Row i of A enters lane i delayed by i steps; column j of B likewise.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic          w_ok;
        logic [AW-1:0] w_idx;
        assign w_ok  = lane_idx_ok(int'(i_t), i, N);
        assign w_idx = AW'(i_t - TW'(i));
        assign o_a[i*DW +: DW] = w_ok ? r_a[i][w_idx] : '0;
        assign o_b[i*DW +: DW] = w_ok ? r_b[w_idx][i] : '0;
    end
endmodule

// File: rtl/pe_array_feeder.sv
// Systolic input sequencer: streams skewed A rows / B columns into an NxN PE
// array, zero-pads for a drain interval, then pulses done.
module pe_array_feeder
    import pe_feed_pkg::*;
#(
    parameter int N         = PE_N,
    parameter int DW        = PE_DW,
    parameter int DRAIN_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    pe_array_feeder_if.slave    bus
);
    localparam int TW  = $clog2(2*N);
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(2*N - 2);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYC - 1);

    state_t          r_state;
    logic [TW-1:0]   r_t;
    logic [DCW-1:0]  r_dcnt;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic [N*DW-1:0] r_a_out;
    logic [N*DW-1:0] r_b_out;

    logic            w_wr_en;
    logic [N*DW-1:0] w_a;
    logic [N*DW-1:0] w_b;

    assign w_wr_en = bus.wr_en && (r_state == IDLE);

    pe_feed_mem #(.N(N), .DW(DW)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_sel  (bus.wr_sel),
        .i_wr_row  (bus.wr_row),
        .i_wr_col  (bus.wr_col),
        .i_wr_data (bus.wr_data),
        .i_t       (r_t),
        .o_a       (w_a),
        .o_b       (w_b)
    );

    // Outputs are captured from the current state, so they trail the FSM by
    // one cycle: STREAM step t appears the edge after r_t holds t.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_a_out <= '0;
            r_b_out <= '0;
        end else begin
            r_busy  <= (r_state != IDLE);
            r_done  <= (r_state == DONE);
            r_valid <= (r_state == STREAM);
            r_a_out <= (r_state == STREAM) ? w_a : '0;
            r_b_out <= (r_state == STREAM) ? w_b : '0;
            case (r_state)
                IDLE: begin
                    r_t    <= '0;
                    r_dcnt <= '0;
                    if (bus.start) r_state <= STREAM;
                end
                STREAM: begin
                    if (r_t == T_LAST) r_state <= DRAIN;
                    else               r_t     <= r_t + 1'b1;
                end
                DRAIN: begin
                    if (r_dcnt == D_LAST) r_state <= DONE;
                    else                  r_dcnt  <= r_dcnt + 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.valid_out = r_valid;
    assign bus.a_out     = r_a_out;
    assign bus.b_out     = r_b_out;
endmodule
